gate_actuator_driver: RTL



---
 rtl/gate_actuator_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gate_actuator_driver.sv
// Barrier motor sequencer: turns single-cycle open/close command pulses into
// level-held motor drives through OPENING, OPEN_HOLD and CLOSING phases.
// A single counter times the phases. Every output is a register loaded from
// the next-state decode, so outputs follow the state without an extra cycle
// of delay and are free of glitches.
// A closing barrier reverses on obstruct or open_req. The new opening count
// is chosen so that the remaining travel equals the closing time already
// spent.
module gate_actuator_driver #(
  parameter int unsigned CLK_FREQUENCY = 40_000_000,
  parameter int unsigned TRAVEL_TICKS  = CLK_FREQUENCY * 2,
  parameter int unsigned HOLD_TICKS    = CLK_FREQUENCY * 5,
  parameter int unsigned COUNT_W       = 28
) (
  input  logic clk,
  input  logic reset_n,
  input  logic open_req,
  input  logic close_req,
  input  logic obstruct,
  output logic motor_open,
  output logic motor_close,
  output logic gate_open,
  output logic busy,
  output logic done_pulse
);

  localparam logic [COUNT_W-1:0] TRAVEL_LAST = COUNT_W'(TRAVEL_TICKS - 1);
  localparam logic [COUNT_W-1:0] HOLD_LAST   = COUNT_W'(HOLD_TICKS - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);

  // Three state bits leave spare encodings; the spare encodings fall back to CLOSED.
  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_OPENING   = 3'd1,
    ST_OPEN_HOLD = 3'd2,
    ST_CLOSING   = 3'd3
  } state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_d;
  logic               motor_open_q, motor_close_q, gate_open_q, busy_q, done_q;

  // Next-state, next-count and completion-pulse decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        if (open_req) begin
          state_d = ST_OPENING;
          count_d = '0;
        end
      end
      ST_OPENING: begin
        if (count_q == TRAVEL_LAST) begin
          state_d = ST_OPEN_HOLD;
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      ST_OPEN_HOLD: begin
        if (obstruct) begin
          count_d = '0;
        end else if (open_req) begin
          count_d = '0;
        end else if (close_req || (count_q == HOLD_LAST)) begin
          state_d = ST_CLOSING;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      ST_CLOSING: begin
        if (obstruct || open_req) begin
          state_d = ST_OPENING;
          count_d = TRAVEL_LAST - count_q;
        end else if (count_q == TRAVEL_LAST) begin
          state_d = ST_CLOSED;
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_CLOSED;
        count_d = '0;
      end
    endcase
  end

  // State, counter and registered Moore outputs; reset drops the drives at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_CLOSED;
      count_q       <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      gate_open_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      motor_open_q  <= (state_d == ST_OPENING);
      motor_close_q <= (state_d == ST_CLOSING);
      gate_open_q   <= (state_d == ST_OPEN_HOLD);
      busy_q        <= (state_d != ST_CLOSED);
      done_q        <= done_d;
    end
  end

  assign motor_open  = motor_open_q;
  assign motor_close = motor_close_q;
  assign gate_open   = gate_open_q;
  assign busy        = busy_q;
  assign done_pulse  = done_q;

endmodule
